// File: rtl/afe_ro_buf_ctrl.sv
// ---------------------------------------------------------------------------
// afe_ro_buf_ctrl
// Readout buffer controller for an AFE ADC channel. It takes synchronized
// samples, queues them in a 2-entry FIFO, and writes them to a memory buffer
// that is either single-shot or circular. It also sequences the enable and
// clear pulses towards the sync interface.
//
// Ports
//   clk_i, rstn_i            : clock, synchronous active-low reset
//   cfg_*                    : buffer configuration, start/stop pulses
//   adc_valid_i/adc_data_i   : one-cycle sample strobe and sample
//   buf_cfg_*_o              : enable/clear pulses, trigger mode/channel
//   wr_req_o/wr_gnt_i        : memory write handshake
//   wr_addr_o/wr_data_o      : write byte address and data (FIFO head)
//   busy_o, overflow_o       : status (not IDLE, sticky sample drop)
//   evt_half_o, evt_full_o   : half / full-or-wrap event pulses, issued
//                              the cycle after the matching grant
// ---------------------------------------------------------------------------
module afe_ro_buf_ctrl #(
  parameter int ADC_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 19,
  parameter int SIZE_WIDTH     = 16,
  parameter int ADC_CHID_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [ADDR_WIDTH-1:0]     cfg_start_addr_i,
  input  logic [SIZE_WIDTH-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_trig_i,
  input  logic [ADC_CHID_WIDTH-1:0] cfg_trig_chid_i,
  input  logic                      cfg_start_i,
  input  logic                      cfg_stop_i,
  input  logic                      adc_valid_i,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data_i,
  output logic                      buf_cfg_en_o,
  output logic                      buf_cfg_clr_o,
  output logic                      buf_cfg_mode_o,
  output logic [ADC_CHID_WIDTH-1:0] buf_cfg_en_chid_o,
  output logic                      wr_req_o,
  input  logic                      wr_gnt_i,
  output logic [ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [ADC_DATA_WIDTH-1:0] wr_data_o,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic                      evt_half_o,
  output logic                      evt_full_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;

  localparam logic [SIZE_WIDTH-1:0] SIZE_ZERO = {SIZE_WIDTH{1'b0}};
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE  = SIZE_WIDTH'(1'b1);
  localparam logic [SIZE_WIDTH-1:0] SIZE_TWO  = SIZE_WIDTH'(2'd2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(3'd4);

  logic [2:0]                state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]     start_addr_r, wr_addr_r;
  logic [SIZE_WIDTH-1:0]     size_r, wr_idx_r, acc_cnt_r, half_idx_s;
  logic                      cont_r, mode_r;
  logic [ADC_CHID_WIDTH-1:0] chid_r;
  logic [ADC_DATA_WIDTH-1:0] fifo_mem_r [2];
  logic                      rd_ptr_r, wr_ptr_r;
  logic [1:0]                count_r;
  logic                      overflow_r, evt_half_r, evt_full_r;

  logic req_s, pop_s, full_s, sample_s, push_s, drop_s;
  logic idx_last_s, idx_half_s, ss_done_s, start_ok_s;

  // Handshake, FIFO push/pop/drop and buffer-index decode.
  always_comb begin
    start_ok_s = cfg_start_i && (cfg_size_i != SIZE_ZERO);
    req_s      = (count_r != 2'd0) && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    pop_s      = req_s && wr_gnt_i;
    // Fullness is judged before the same-cycle pop, so push+pop while full is accepted.
    full_s     = (count_r == 2'd2);
    sample_s   = (state_r == ST_RUN) && adc_valid_i;
    push_s     = sample_s && (!full_s || pop_s);
    drop_s     = sample_s && full_s && !pop_s;
    idx_last_s = (wr_idx_r == (size_r - SIZE_ONE));
    half_idx_s = {1'b0, size_r[SIZE_WIDTH-1:1]} - SIZE_ONE;
    idx_half_s = (size_r >= SIZE_TWO) && (wr_idx_r == half_idx_s);
    // Single-shot ends when the accepted-sample count reaches the buffer size.
    ss_done_s  = !cont_r && push_s && ((acc_cnt_r + SIZE_ONE) == size_r);
  end

  // Next-state logic of the buffer sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_stop_i || ss_done_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (count_r == 2'd0) begin
          state_nxt_s = ST_CLR;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_CLR: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, configuration latch, FIFO storage, write pointer and status flags.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r       <= ST_IDLE;
      start_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_addr_r     <= {ADDR_WIDTH{1'b0}};
      size_r        <= SIZE_ZERO;
      wr_idx_r      <= SIZE_ZERO;
      acc_cnt_r     <= SIZE_ZERO;
      cont_r        <= 1'b0;
      mode_r        <= 1'b0;
      chid_r        <= {ADC_CHID_WIDTH{1'b0}};
      fifo_mem_r[0] <= {ADC_DATA_WIDTH{1'b0}};
      fifo_mem_r[1] <= {ADC_DATA_WIDTH{1'b0}};
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      overflow_r    <= 1'b0;
      evt_half_r    <= 1'b0;
      evt_full_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      evt_half_r <= pop_s && idx_half_s;
      evt_full_r <= pop_s && idx_last_s;
      if ((state_r == ST_IDLE) && start_ok_s) begin
        start_addr_r <= cfg_start_addr_i;
        wr_addr_r    <= cfg_start_addr_i;
        size_r       <= cfg_size_i;
        cont_r       <= cfg_continuous_i;
        mode_r       <= cfg_trig_i;
        chid_r       <= cfg_trig_chid_i;
        wr_idx_r     <= SIZE_ZERO;
        acc_cnt_r    <= SIZE_ZERO;
        rd_ptr_r     <= 1'b0;
        wr_ptr_r     <= 1'b0;
        count_r      <= 2'd0;
        overflow_r   <= 1'b0;
      end else begin
        if (push_s) begin
          fifo_mem_r[wr_ptr_r] <= adc_data_i;
          wr_ptr_r             <= ~wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
          // The address register tracks start + 4*idx and reloads on wrap,
          // which keeps the sum modulo the address width for free.
          if (idx_last_s) begin
            wr_idx_r  <= SIZE_ZERO;
            wr_addr_r <= start_addr_r;
          end else begin
            wr_idx_r  <= wr_idx_r + SIZE_ONE;
            wr_addr_r <= wr_addr_r + ADDR_STEP;
          end
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + 2'd1;
          2'b01:   count_r <= count_r - 2'd1;
          default: count_r <= count_r;
        endcase
        if (push_s && !cont_r) begin
          acc_cnt_r <= acc_cnt_r + SIZE_ONE;
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // All outputs are decoded from registers only.
  assign buf_cfg_en_o      = (state_r == ST_ARM);
  assign buf_cfg_clr_o     = (state_r == ST_CLR);
  assign buf_cfg_mode_o    = mode_r;
  assign buf_cfg_en_chid_o = chid_r;
  assign wr_req_o          = req_s;
  assign wr_addr_o         = wr_addr_r;
  assign wr_data_o         = fifo_mem_r[rd_ptr_r];
  assign busy_o            = (state_r != ST_IDLE);
  assign overflow_o        = overflow_r;
  assign evt_half_o        = evt_half_r;
  assign evt_full_o        = evt_full_r;

endmodule

// File: tb/tb_afe_ro_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_afe_ro_buf_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_afe_ro_buf_ctrl;

  localparam int DW = 32;
  localparam int AW = 19;
  localparam int SW = 16;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [AW-1:0] cfg_start_addr_i = '0;
  logic [SW-1:0] cfg_size_i = '0;
  logic          cfg_continuous_i = 1'b0;
  logic          cfg_trig_i = 1'b0;
  logic [CW-1:0] cfg_trig_chid_i = '0;
  logic          cfg_start_i = 1'b0;
  logic          cfg_stop_i = 1'b0;
  logic          adc_valid_i = 1'b0;
  logic [DW-1:0] adc_data_i = '0;
  logic          wr_gnt_i = 1'b0;
  logic          buf_cfg_en_o, buf_cfg_clr_o, buf_cfg_mode_o;
  logic [CW-1:0] buf_cfg_en_chid_o;
  logic          wr_req_o, busy_o, overflow_o, evt_half_o, evt_full_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;

  afe_ro_buf_ctrl #(
    .ADC_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .ADC_CHID_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_start_addr_i(cfg_start_addr_i), .cfg_size_i(cfg_size_i),
    .cfg_continuous_i(cfg_continuous_i), .cfg_trig_i(cfg_trig_i),
    .cfg_trig_chid_i(cfg_trig_chid_i), .cfg_start_i(cfg_start_i),
    .cfg_stop_i(cfg_stop_i), .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
    .buf_cfg_en_o(buf_cfg_en_o), .buf_cfg_clr_o(buf_cfg_clr_o),
    .buf_cfg_mode_o(buf_cfg_mode_o), .buf_cfg_en_chid_o(buf_cfg_en_chid_o),
    .wr_req_o(wr_req_o), .wr_gnt_i(wr_gnt_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .overflow_o(overflow_o),
    .evt_half_o(evt_half_o), .evt_full_o(evt_full_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARM, M_RUN, M_DRAIN, M_CLR} mphase_t;
  mphase_t       m_ph = M_IDLE;
  logic [DW-1:0] m_q[$];
  int            m_base, m_size, m_idx, m_acc, m_chid;
  bit            m_cont, m_trig, m_ovf, m_half, m_full, m_rst_seen;
  int            obs_addrs[$];
  int            n_en, n_clr, n_half, n_full;

  task automatic model_edge();
    bit req, grant, full_pre;
    req   = (m_q.size() > 0) && (m_ph == M_RUN || m_ph == M_DRAIN);
    grant = req && wr_gnt_i;
    m_half = 1'b0; m_full = 1'b0; m_rst_seen = 1'b0;
    if (!rstn_i) begin
      m_ph = M_IDLE; m_q.delete(); m_base = 0; m_size = 0; m_idx = 0; m_acc = 0;
      m_chid = 0; m_cont = 1'b0; m_trig = 1'b0; m_ovf = 1'b0; m_rst_seen = 1'b1;
      return;
    end
    full_pre = (m_q.size() >= 2);
    if (grant) begin
      m_half = (m_size >= 2) && (m_idx == m_size / 2 - 1);
      m_full = (m_idx == m_size - 1);
      m_idx  = (m_idx + 1) % m_size;
      void'(m_q.pop_front());
    end
    case (m_ph)
      M_IDLE: if (cfg_start_i && cfg_size_i != 0) begin
        m_base = int'(cfg_start_addr_i); m_size = int'(cfg_size_i);
        m_cont = cfg_continuous_i; m_trig = cfg_trig_i; m_chid = int'(cfg_trig_chid_i);
        m_ovf = 1'b0; m_idx = 0; m_acc = 0; m_q.delete(); m_ph = M_ARM;
      end
      M_ARM: m_ph = M_RUN;
      M_RUN: begin
        if (adc_valid_i) begin
          if (!full_pre || grant) begin
            m_q.push_back(adc_data_i);
            m_acc++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (cfg_stop_i || (!m_cont && m_acc == m_size)) m_ph = M_DRAIN;
      end
      M_DRAIN: if (!req) m_ph = M_CLR;
      M_CLR: m_ph = M_IDLE;
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    bit exp_req;
    longint exp_addr;
    exp_req  = (m_q.size() > 0) && (m_ph == M_RUN || m_ph == M_DRAIN);
    exp_addr = (longint'(m_base) + 4 * longint'(m_idx)) % (longint'(1) << AW);
    check_eq("busy", busy_o, m_ph != M_IDLE);
    check_eq("cfg_en", buf_cfg_en_o, m_ph == M_ARM);
    check_eq("cfg_clr", buf_cfg_clr_o, m_ph == M_CLR);
    check_eq("cfg_mode", buf_cfg_mode_o, m_trig);
    check_eq("cfg_chid", buf_cfg_en_chid_o, m_chid);
    check_eq("wr_req", wr_req_o, exp_req);
    check_eq("wr_addr", wr_addr_o, exp_addr);
    check_eq("overflow", overflow_o, m_ovf);
    check_eq("evt_half", evt_half_o, m_half);
    check_eq("evt_full", evt_full_o, m_full);
    if (exp_req) check_eq("wr_data", wr_data_o, m_q[0]);
    if (m_rst_seen) check_eq("wr_data_rst", wr_data_o, 0);
    n_en   += int'(buf_cfg_en_o);
    n_clr  += int'(buf_cfg_clr_o);
    n_half += int'(evt_half_o);
    n_full += int'(evt_full_o);
  endtask

  // One clock: record an observed grant, advance the model, then compare.
  task automatic step();
    bit            g;
    logic [AW-1:0] a;
    g = wr_req_o && wr_gnt_i;
    a = wr_addr_o;
    @(posedge clk_i);
    if (g) obs_addrs.push_back(int'(a));
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic cyc(input bit st, input bit sp, input bit v, input bit g);
    cfg_start_i = st; cfg_stop_i = sp; adc_valid_i = v; wr_gnt_i = g;
    adc_data_i  = DW'($urandom);
    step();
  endtask

  task automatic cfg(input int addr, input int size, input bit cont, input bit trig, input int chid);
    cfg_start_addr_i = AW'(addr); cfg_size_i = SW'(size); cfg_continuous_i = cont;
    cfg_trig_i = trig; cfg_trig_chid_i = CW'(chid);
  endtask

  task automatic clear_stats();
    obs_addrs.delete(); n_en = 0; n_clr = 0; n_half = 0; n_full = 0;
  endtask

  initial begin
    // Reset state
    rstn_i = 1'b0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rstn_i = 1'b1;

    // V1: single-shot, size 4, immediate grants
    clear_stats();
    cfg(32'h100, 4, 1'b0, 1'b1, 5);
    cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1);
    check_eq("v1_nwr", obs_addrs.size(), 4);
    for (int i = 0; i < 4 && i < obs_addrs.size(); i++)
      check_eq("v1_addr", obs_addrs[i], 32'h100 + 4 * i);
    check_eq("v1_en", n_en, 1); check_eq("v1_clr", n_clr, 1);
    check_eq("v1_half", n_half, 1); check_eq("v1_full", n_full, 1);
    check_eq("v1_idle", busy_o, 0);

    // V2: continuous, size 3, 7 samples
    clear_stats();
    cfg(32'h200, 3, 1'b1, 1'b0, 2);
    cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    check_eq("v2_full", n_full, 2); check_eq("v2_half", n_half, 3);
    check_eq("v2_addr3", obs_addrs.size() > 3 ? obs_addrs[3] : -1, 32'h200);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // V3: grant stalled, third sample dropped; V4: full with push+pop
    cfg(32'h300, 8, 1'b1, 1'b0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check_eq("v3_ovf", overflow_o, 1);
    cyc(0, 1, 0, 1); for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cfg(32'h300, 8, 1'b1, 1'b0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    check_eq("v3_ovf_clr", overflow_o, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    check_eq("v4_ovf", overflow_o, 0);

    // V5: stop with 2 queued, later sample ignored
    cyc(0, 0, 1, 0);
    clear_stats();
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
    check_eq("v5_nwr", obs_addrs.size(), 2); check_eq("v5_clr", n_clr, 1);

    // V6: reset during RUN with a pending request
    cfg(32'h7FFF8, 5, 1'b1, 1'b1, 9);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check_eq("v6_req_pre", wr_req_o, 1);
    clear_stats();
    rstn_i = 1'b0; cyc(0, 0, 0, 0); rstn_i = 1'b1;
    check_eq("v6_req", wr_req_o, 0); check_eq("v6_busy", busy_o, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    check_eq("v6_clr", n_clr, 0);

    // Randomized traffic, including address wrap near the top
    for (int i = 0; i < 5000; i++) begin
      rstn_i = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0)
        cfg(($urandom_range(0, 2) == 0) ? 32'h7FFE0 + $urandom_range(0, 31) : int'($urandom_range(0, 32'h7FFFF)),
            $urandom_range(0, 6), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
